reg_bank_arbiter: RTL and testbench
===================================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have one clock `clk` and a reset `rst`, which is asynchronous and active-high.
REQ-002 The block SHALL provide parameter WIDTH, default 8: register width in bits.
REQ-003 The block SHALL provide parameter MAX_HOLD, default 15: maximum consecutive granted cycles before revoke (range 1..255).
REQ-004 Ports SHALL be exactly:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  4  per-requester access request
- we  input  4  per-requester write enable
- wdata  input  4*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  4  one-hot grant, registered
- owner  output  2  index of current grantee; valid while busy=1
- busy  output  1  a grant is active
- q  output  WIDTH  shared register contents, registered
- timeout_o  output  1  one-cycle pulse on revoke

Function
REQ-005 FSM SHALL have states IDLE, BUSY and REVOKE.
REQ-006 IDLE with req!=0 at edge SHALL select the first requester found searching upward from (last_ptr+1) mod 4, set gnt one-hot, set owner and busy, and go to BUSY.
- Grant visible one cycle after req is sampled.
REQ-007 IDLE with req==0 SHALL hold gnt=0 and busy=0.
REQ-008 BUSY with req[owner]=1 SHALL hold gnt, and SHALL load q with wdata slice [owner] on every edge where we[owner]=1.
REQ-009 Writes (we[i]=1) from non-granted requesters SHALL be ignored, and q SHALL hold when no granted write occurs.
REQ-010 BUSY with req[owner]=0 at edge SHALL clear gnt and busy, set last_ptr=owner, and go to IDLE.
- Exactly one dead cycle then occurs before any new grant, including when other requests are pending.
REQ-011 we[owner] sampled together with req[owner]=0 SHALL be ignored; release takes priority.
REQ-012 last_ptr SHALL update only on release or revoke, never on grant.
REQ-013 gnt SHALL never have more than one bit set, and SHALL always equal the one-hot decode of owner when busy=1.

Reset
REQ-014 While rst=1, the block SHALL immediately clear gnt=0, busy=0, owner=0, q=0, timeout_o=0 and hold count=0, force state=IDLE and last_ptr=3, independent of clk.
- After reset, requester 0 has highest priority.
REQ-015 Reset asserted mid-grant SHALL discard the grant with no write completing.
- After release, arbitration restarts from IDLE on the first rising edge with rst=0.

Configuration
REQ-016 With macro REG_BANK_ARBITER_TIMEOUT_EN defined, an internal hold counter SHALL count edges in BUSY.
- The counter clears on entering BUSY.
- On the edge where count reaches MAX_HOLD with req[owner] still 1: gnt and busy clear, the write on that edge is suppressed, timeout_o pulses for one cycle, last_ptr=owner, and state goes to REVOKE.
- REVOKE lasts one cycle, then goes to IDLE.
- The revoked requester is excluded from the next single arbitration only.
REQ-017 Without REG_BANK_ARBITER_TIMEOUT_EN, the counter and REVOKE state SHALL be absent, timeout_o SHALL be tied to 0, and a grant SHALL persist indefinitely while req[owner]=1.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- V1: rst=1 for 2 cycles, then release; req=4'b1111 -> gnt=0001 one cycle later; q=0 until the first write.
- V2: req[2] alone, we[2]=1, wdata slice2=8'hA5 for 1 cycle -> q=8'hA5 the next cycle; simultaneous we[0]=1 with 8'h11 has no effect.
- V3: req=4'b1111 held; each owner drops req after 2 cycles, then re-raises -> grant order 0,1,2,3,0, with exactly one idle cycle between grants.
- V4: rst pulsed while gnt=0100 and we[2]=1 -> gnt=0, q=0 with no clock edge; next grant goes to requester 0.
- V5 (TIMEOUT_EN, MAX_HOLD=3): req[1] held with req[3] pending -> timeout_o pulses 3 edges after grant; next grant goes to requester 3, not 1.
- V6 (TIMEOUT_EN undefined): req[1] held 300 cycles -> gnt stays 0010 and timeout_o stays 0 throughout.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: 4-way round-robin arbiter guarding one shared WIDTH-bit register.
// Optional hold-timeout revoke is enabled by defining REG_BANK_ARBITER_TIMEOUT_EN.
module reg_bank_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [3:0]         we,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
    output logic [WIDTH-1:0]   q,
    output logic               timeout_o
);
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, REVOKE} state_t;
    logic [7:0] count_q, count_d;
    logic       excl_q, excl_d;
    logic       timeout_q, timeout_d;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif
    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_ptr_q, last_ptr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [3:0]       cand;
    logic [1:0]       idx;
    logic [1:0]       pick;
    logic             found;

    // State register; reset leaves last_ptr=3 so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_ptr_q <= 2'd3;
            busy_q     <= 1'b0;
            q_q        <= '0;
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
            count_q    <= '0;
            excl_q     <= 1'b0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
            busy_q     <= busy_d;
            q_q        <= q_d;
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
            count_q    <= count_d;
            excl_q     <= excl_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Round-robin search starting just above last_ptr; a revoked owner sits out one arbitration
    always_comb begin
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
        cand = req & ~(excl_q ? (4'b0001 << last_ptr_q) : 4'b0000);
`else
        cand = req;
`endif
        pick  = last_ptr_q;
        found = 1'b0;
        idx   = last_ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_ptr_q + 2'(i);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic; release beats a write sampled on the same edge
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        busy_d     = busy_q;
        q_d        = q_q;
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
        count_d    = count_q;
        excl_d     = excl_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
                excl_d  = 1'b0;
                count_d = '0;
`endif
                if (found) begin
                    state_d = BUSY;
                    owner_d = pick;
                    gnt_d   = 4'b0001 << pick;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                if (!req[owner_q]) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    busy_d     = 1'b0;
                    last_ptr_d = owner_q;
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
                end else if (count_q == 8'(MAX_HOLD - 1)) begin
                    state_d    = REVOKE;
                    gnt_d      = '0;
                    busy_d     = 1'b0;
                    last_ptr_d = owner_q;
                    excl_d     = 1'b1;
                    timeout_d  = 1'b1;
`endif
                end else begin
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
                    count_d = count_q + 8'd1;
`endif
                    if (we[owner_q]) q_d = wdata[owner_q*WIDTH +: WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from flops
    always_comb begin
        gnt   = gnt_q;
        owner = owner_q;
        busy  = busy_q;
        q     = q_q;
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
        timeout_o = timeout_q;
`else
        timeout_o = 1'b0;
`endif
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed table-driven bench for reg_bank_arbiter (WIDTH=8, MAX_HOLD=3).
module tb_reg_bank_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic        timeout_o;
    int          checks;
    int          failures;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
        logic [7:0]  q;
    } vec_t;

    vec_t v[16];

    reg_bank_arbiter #(.WIDTH(8), .MAX_HOLD(3)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt), .owner(owner), .busy(busy), .q(q), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req = '0;
        we = '0;
        wdata = '0;
        // V1: reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        rst = 1'b0;
        // V1/V3 round robin with one dead cycle, plus writes and release-priority
        v[0]  = '{4'b1111, 4'b0000, 32'h0,         4'b0001, 1'b1, 2'd0, 8'h00};
        v[1]  = '{4'b1111, 4'b0011, 32'h0000773C,  4'b0001, 1'b1, 2'd0, 8'h3C};
        v[2]  = '{4'b1110, 4'b0001, 32'h00000099,  4'b0000, 1'b0, 2'd0, 8'h3C};
        v[3]  = '{4'b1111, 4'b0000, 32'h0,         4'b0010, 1'b1, 2'd1, 8'h3C};
        v[4]  = '{4'b1111, 4'b0010, 32'h00005A00,  4'b0010, 1'b1, 2'd1, 8'h5A};
        v[5]  = '{4'b1101, 4'b0000, 32'h0,         4'b0000, 1'b0, 2'd1, 8'h5A};
        v[6]  = '{4'b1111, 4'b0000, 32'h0,         4'b0100, 1'b1, 2'd2, 8'h5A};
        v[7]  = '{4'b1111, 4'b0000, 32'h0,         4'b0100, 1'b1, 2'd2, 8'h5A};
        v[8]  = '{4'b1011, 4'b0000, 32'h0,         4'b0000, 1'b0, 2'd2, 8'h5A};
        v[9]  = '{4'b1111, 4'b0000, 32'h0,         4'b1000, 1'b1, 2'd3, 8'h5A};
        v[10] = '{4'b1111, 4'b0000, 32'h0,         4'b1000, 1'b1, 2'd3, 8'h5A};
        v[11] = '{4'b0111, 4'b0000, 32'h0,         4'b0000, 1'b0, 2'd3, 8'h5A};
        v[12] = '{4'b1111, 4'b0001, 32'h000000EE,  4'b0001, 1'b1, 2'd0, 8'h5A};
        v[13] = '{4'b0001, 4'b0001, 32'h000000EE,  4'b0001, 1'b1, 2'd0, 8'hEE};
        v[14] = '{4'b0000, 4'b0000, 32'h0,         4'b0000, 1'b0, 2'd0, 8'hEE};
        v[15] = '{4'b0000, 4'b0000, 32'h0,         4'b0000, 1'b0, 2'd0, 8'hEE};
        for (int i = 0; i < 16; i++) begin
            req = v[i].req;
            we = v[i].we;
            wdata = v[i].wdata;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].busy));
            chk($sformatf("v%0d_owner", i), 32'(owner), 32'(v[i].owner));
            chk($sformatf("v%0d_q", i), 32'(q), 32'(v[i].q));
            chk($sformatf("v%0d_timeout", i), 32'(timeout_o), 0);
        end
        // V2: only the granted requester's write lands
        req = 4'b0100;
        we = 4'b0000;
        step();
        chk("v2_gnt", 32'(gnt), 32'h4);
        we = 4'b0101;
        wdata = 32'h00A50011;
        step();
        chk("v2_q", 32'(q), 32'hA5);
        we = 4'b0000;
        step();
        chk("v2_hold_q", 32'(q), 32'hA5);
        chk("v2_hold_gnt", 32'(gnt), 32'h4);
        // V4: asynchronous reset mid-grant
        we = 4'b0100;
        wdata = 32'h00C30000;
        #2;
        rst = 1'b1;
        #1;
        chk("v4_gnt", 32'(gnt), 0);
        chk("v4_busy", 32'(busy), 0);
        chk("v4_q", 32'(q), 0);
        chk("v4_owner", 32'(owner), 0);
        step();
        rst = 1'b0;
        req = 4'b1111;
        we = 4'b0000;
        step();
        chk("v4_regrant", 32'(gnt), 32'h1);
        chk("v4_q_after", 32'(q), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef REG_BANK_ARBITER_TIMEOUT_EN
        // V5: hold timeout revokes requester 1, requester 3 is next
        req = 4'b1010;
        step();
        chk("v5_grant", 32'(gnt), 32'h2);
        chk("v5_to_g0", 32'(timeout_o), 0);
        step();
        chk("v5_gnt_g1", 32'(gnt), 32'h2);
        chk("v5_to_g1", 32'(timeout_o), 0);
        step();
        chk("v5_gnt_g2", 32'(gnt), 32'h2);
        chk("v5_to_g2", 32'(timeout_o), 0);
        we = 4'b0010;
        wdata = 32'h00004200;
        step();
        chk("v5_to_pulse", 32'(timeout_o), 1);
        chk("v5_gnt_revoked", 32'(gnt), 0);
        chk("v5_busy_revoked", 32'(busy), 0);
        chk("v5_q_suppressed", 32'(q), 0);
        we = 4'b0000;
        step();
        chk("v5_to_end", 32'(timeout_o), 0);
        chk("v5_gnt_revoke", 32'(gnt), 0);
        step();
        chk("v5_next_gnt", 32'(gnt), 32'h8);
        chk("v5_next_owner", 32'(owner), 3);
`else
        // V6: no timeout, grant persists
        req = 4'b0010;
        step();
        chk("v6_grant", 32'(gnt), 32'h2);
        for (int i = 0; i < 300; i++) begin
            step();
            chk("v6_gnt", 32'(gnt), 32'h2);
            chk("v6_timeout", 32'(timeout_o), 0);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
